// File: rtl/mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_if
// Bundles the controller's datapath-facing signals.
//   master : the controller side. It consumes the decoded opcode/funct, the ALU
//            flags and the memory ready, and it drives the datapath enables and
//            selects plus the debug state.
//   slave  : the datapath side, which is the mirror image of master.
// -----------------------------------------------------------------------------
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       alu_ovf;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       ext_op;
    logic       mem_read;
    logic       mem_write;
    logic       ovf_trap;
    logic [2:0] state;

    modport master (
        input  opcode, funct, zero, alu_ovf, mem_ready,
        output pc_write, pc_src, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src, alu_op, ext_op, mem_read, mem_write, ovf_trap, state
    );

    modport slave (
        output opcode, funct, zero, alu_ovf, mem_ready,
        input  pc_write, pc_src, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src, alu_op, ext_op, mem_read, mem_write, ovf_trap, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl
// This is the multi-cycle MIPS control FSM. It steps through the states
// FETCH, DECODE, EXEC, MEM, WB and TRAP. Only the state is held in a register.
// Every control output is decoded from that state and from the current
// opcode, funct and zero inputs.
// The overflow trap pulses ovf_trap for one cycle, and on that cycle the PC
// loads the exception vector.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset. While it is high, all enables and
//          selects are held at 0.
//   bus  - mc_ctrl_if.master (opcode/funct/zero/alu_ovf/mem_ready in, and the
//          datapath controls plus the debug state out)
// Parameter:
//   TRAP_ON_UNKNOWN - when set, an unrecognised instruction goes to TRAP.
//                     When clear, it acts as a NOP and returns to FETCH.
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter bit TRAP_ON_UNKNOWN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    mc_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        I_ADDU = 4'd0,
        I_SUBU = 4'd1,
        I_ADD  = 4'd2,
        I_SUB  = 4'd3,
        I_JR   = 4'd4,
        I_ADDI = 4'd5,
        I_ORI  = 4'd6,
        I_LUI  = 4'd7,
        I_LW   = 4'd8,
        I_SW   = 4'd9,
        I_BEQ  = 4'd10,
        I_J    = 4'd11,
        I_JAL  = 4'd12,
        I_UNK  = 4'd13
    } instr_e;

    state_e     state_q;
    state_e     state_d;
    instr_e     instr_s;
    logic       is_rtype_s;

    logic       pc_write_s;
    logic [1:0] pc_src_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] reg_dst_s;
    logic [1:0] mem_to_reg_s;
    logic       alu_src_s;
    logic [1:0] alu_op_s;
    logic       ext_op_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ovf_trap_s;

    // Decode the opcode and funct into an instruction class
    always_comb begin
        instr_s = I_UNK;
        case (bus.opcode)
            6'b000000: begin
                case (bus.funct)
                    6'b100001: instr_s = I_ADDU;
                    6'b100011: instr_s = I_SUBU;
                    6'b100000: instr_s = I_ADD;
                    6'b100010: instr_s = I_SUB;
                    6'b001000: instr_s = I_JR;
                    default:   instr_s = I_UNK;
                endcase
            end
            6'b001000: instr_s = I_ADDI;
            6'b001101: instr_s = I_ORI;
            6'b001111: instr_s = I_LUI;
            6'b100011: instr_s = I_LW;
            6'b101011: instr_s = I_SW;
            6'b000100: instr_s = I_BEQ;
            6'b000010: instr_s = I_J;
            6'b000011: instr_s = I_JAL;
            default:   instr_s = I_UNK;
        endcase
    end

    assign is_rtype_s = (bus.opcode == 6'b000000);

    // Compute the next state and the control outputs for the current state.
    // While reset is active, everything is forced to 0 so that no request,
    // including a pending memory access, can survive the reset.
    always_comb begin
        state_d      = state_q;
        pc_write_s   = 1'b0;
        pc_src_s     = 2'd0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = 2'd0;
        mem_to_reg_s = 2'd0;
        alu_src_s    = 1'b0;
        alu_op_s     = 2'd0;
        ext_op_s     = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ovf_trap_s   = 1'b0;
        if (rst) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end
                S_DECODE: begin
                    case (instr_s)
                        I_J: begin
                            pc_write_s = 1'b1;
                            pc_src_s   = 2'd2;
                            state_d    = S_FETCH;
                        end
                        I_JAL: begin
                            pc_write_s   = 1'b1;
                            pc_src_s     = 2'd2;
                            reg_write_s  = 1'b1;
                            reg_dst_s    = 2'd2;
                            mem_to_reg_s = 2'd2;
                            state_d      = S_FETCH;
                        end
                        I_JR: begin
                            pc_write_s = 1'b1;
                            pc_src_s   = 2'd3;
                            state_d    = S_FETCH;
                        end
                        I_UNK:   state_d = TRAP_ON_UNKNOWN ? S_TRAP : S_FETCH;
                        default: state_d = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    // Signed overflow only traps for add, sub and addi. The
                    // unsigned forms, ori and lui ignore alu_ovf.
                    case (instr_s)
                        I_ADDU: begin
                            state_d = S_WB;
                        end
                        I_SUBU: begin
                            alu_op_s = 2'd1;
                            state_d  = S_WB;
                        end
                        I_ADD: begin
                            state_d = bus.alu_ovf ? S_TRAP : S_WB;
                        end
                        I_SUB: begin
                            alu_op_s = 2'd1;
                            state_d  = bus.alu_ovf ? S_TRAP : S_WB;
                        end
                        I_ADDI: begin
                            alu_src_s = 1'b1;
                            ext_op_s  = 1'b1;
                            state_d   = bus.alu_ovf ? S_TRAP : S_WB;
                        end
                        I_ORI: begin
                            alu_op_s  = 2'd2;
                            alu_src_s = 1'b1;
                            state_d   = S_WB;
                        end
                        I_LUI: begin
                            alu_op_s  = 2'd3;
                            alu_src_s = 1'b1;
                            state_d   = S_WB;
                        end
                        I_LW, I_SW: begin
                            alu_src_s = 1'b1;
                            ext_op_s  = 1'b1;
                            state_d   = S_MEM;
                        end
                        I_BEQ: begin
                            alu_op_s   = 2'd1;
                            ext_op_s   = 1'b1;
                            pc_src_s   = 2'd1;
                            pc_write_s = bus.zero;
                            state_d    = S_FETCH;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    // Hold the request until memory reports completion. There
                    // is no timeout.
                    case (instr_s)
                        I_LW: begin
                            mem_read_s = 1'b1;
                            if (bus.mem_ready) begin
                                state_d = S_WB;
                            end else begin
                                state_d = S_MEM;
                            end
                        end
                        I_SW: begin
                            mem_write_s = 1'b1;
                            if (bus.mem_ready) begin
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_MEM;
                            end
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
                S_WB: begin
                    reg_write_s  = 1'b1;
                    reg_dst_s    = is_rtype_s ? 2'd1 : 2'd0;
                    mem_to_reg_s = (instr_s == I_LW) ? 2'd1 : 2'd0;
                    state_d      = S_FETCH;
                end
                S_TRAP: begin
                    // The PC takes the exception vector on this edge. The
                    // faulting result is never written back.
                    ovf_trap_s = 1'b1;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.pc_write   = pc_write_s;
    assign bus.pc_src     = pc_src_s;
    assign bus.ir_write   = ir_write_s;
    assign bus.reg_write  = reg_write_s;
    assign bus.reg_dst    = reg_dst_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.alu_src    = alu_src_s;
    assign bus.alu_op     = alu_op_s;
    assign bus.ext_op     = ext_op_s;
    assign bus.mem_read   = mem_read_s;
    assign bus.mem_write  = mem_write_s;
    assign bus.ovf_trap   = ovf_trap_s;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl
// Each instruction is expanded into the list of cycles it should take, together
// with the control word expected on each cycle. The list follows directly from
// the instruction's semantics and CPI. The bench then drives the DUT through
// that list and compares every cycle. Inputs change on the falling edge, and
// outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       mem_read;
        logic       mem_write;
        logic       ovf_trap;
    } outs_t;

    // instruction kinds
    localparam int K_ADDU = 0, K_SUBU = 1, K_ADD = 2, K_SUB = 3, K_JR = 4;
    localparam int K_ADDI = 5, K_ORI = 6, K_LUI = 7, K_LW = 8, K_SW = 9;
    localparam int K_BEQ = 10, K_J = 11, K_JAL = 12, K_UNKR = 13, K_UNKOP = 14;
    localparam int NKIND = 15;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    outs_t exp_q[$];
    bit    mr_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    function automatic outs_t observe();
        outs_t o;
        o.st         = bus.state;
        o.pc_write   = bus.pc_write;
        o.pc_src     = bus.pc_src;
        o.ir_write   = bus.ir_write;
        o.reg_write  = bus.reg_write;
        o.reg_dst    = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg;
        o.alu_src    = bus.alu_src;
        o.alu_op     = bus.alu_op;
        o.ext_op     = bus.ext_op;
        o.mem_read   = bus.mem_read;
        o.mem_write  = bus.mem_write;
        o.ovf_trap   = bus.ovf_trap;
        return o;
    endfunction

    function automatic outs_t blank(input logic [2:0] st);
        outs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    task automatic encode(input int k, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (k)
            K_ADDU:  begin op = 6'b000000; fn = 6'b100001; end
            K_SUBU:  begin op = 6'b000000; fn = 6'b100011; end
            K_ADD:   begin op = 6'b000000; fn = 6'b100000; end
            K_SUB:   begin op = 6'b000000; fn = 6'b100010; end
            K_JR:    begin op = 6'b000000; fn = 6'b001000; end
            K_ADDI:  op = 6'b001000;
            K_ORI:   op = 6'b001101;
            K_LUI:   op = 6'b001111;
            K_LW:    op = 6'b100011;
            K_SW:    op = 6'b101011;
            K_BEQ:   op = 6'b000100;
            K_J:     op = 6'b000010;
            K_JAL:   op = 6'b000011;
            K_UNKR:  begin op = 6'b000000; fn = 6'b000000; end
            default: op = 6'b111111;
        endcase
    endtask

    // Build the expected per-cycle sequence for one instruction. This uses the
    // default configuration, where unknown instructions behave as a NOP.
    task automatic build(input int k, input bit ovf, input bit zero_v, input int wait_n);
        outs_t c;
        bit    rtype;
        bit    traps;
        exp_q.delete();
        mr_q.delete();
        rtype = (k <= K_SUB);

        c = blank(3'd0); c.ir_write = 1'b1; c.pc_write = 1'b1;
        exp_q.push_back(c); mr_q.push_back(1'($urandom));

        c = blank(3'd1);
        if (k == K_J || k == K_JAL) begin c.pc_write = 1'b1; c.pc_src = 2'd2; end
        if (k == K_JAL) begin c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2; end
        if (k == K_JR) begin c.pc_write = 1'b1; c.pc_src = 2'd3; end
        exp_q.push_back(c); mr_q.push_back(1'($urandom));
        if (k == K_J || k == K_JAL || k == K_JR || k == K_UNKR || k == K_UNKOP) return;

        c = blank(3'd2);
        if (k == K_SUBU || k == K_SUB) c.alu_op = 2'd1;
        if (k == K_ADDI || k == K_LW || k == K_SW) begin c.alu_src = 1'b1; c.ext_op = 1'b1; end
        if (k == K_ORI) begin c.alu_op = 2'd2; c.alu_src = 1'b1; end
        if (k == K_LUI) begin c.alu_op = 2'd3; c.alu_src = 1'b1; end
        if (k == K_BEQ) begin
            c.alu_op = 2'd1; c.ext_op = 1'b1; c.pc_src = 2'd1; c.pc_write = zero_v;
        end
        exp_q.push_back(c); mr_q.push_back(1'($urandom));
        if (k == K_BEQ) return;

        traps = ovf && (k == K_ADD || k == K_SUB || k == K_ADDI);
        if (traps) begin
            c = blank(3'd5); c.ovf_trap = 1'b1;
            exp_q.push_back(c); mr_q.push_back(1'($urandom));
            return;
        end

        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= wait_n; i++) begin
                c = blank(3'd3);
                c.mem_read  = (k == K_LW);
                c.mem_write = (k == K_SW);
                exp_q.push_back(c); mr_q.push_back(i == wait_n);
            end
            if (k == K_SW) return;
        end

        c = blank(3'd4);
        c.reg_write  = 1'b1;
        c.reg_dst    = rtype ? 2'd1 : 2'd0;
        c.mem_to_reg = (k == K_LW) ? 2'd1 : 2'd0;
        exp_q.push_back(c); mr_q.push_back(1'($urandom));
    endtask

    // Drive one instruction through the DUT and check every cycle. When
    // abort_mem is set, reset is pulsed during the first MEM cycle.
    task automatic run_instr(input int n, input int k, input bit ovf, input bit zero_v,
                             input int wait_n, input bit abort_mem);
        logic [5:0] op;
        logic [5:0] fn;
        outs_t      e;
        encode(k, op, fn);
        build(k, ovf, zero_v, wait_n);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            rst           = 1'b0;
            bus.opcode    = op;
            bus.funct     = fn;
            bus.alu_ovf   = ovf;
            bus.zero      = zero_v;
            bus.mem_ready = mr_q[i];
            #1;
            e = exp_q[i];
            check_eq($sformatf("instr%0d_kind%0d_cyc%0d", n, k, i), {13'd0, observe()}, {13'd0, e});
            if (abort_mem && e.st == 3'd3) begin
                #2 rst = 1'b1;
                #1 check_eq("rst_mid_mem_drop", {13'd0, observe()}, 32'd0);
                @(posedge clk);
                #1 check_eq("rst_mid_mem_hold", {13'd0, observe()}, 32'd0);
                return;
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.opcode    = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b1;
        bus.alu_ovf   = 1'b1;
        bus.mem_ready = 1'b1;

        // While reset is held, every output must stay at 0 whatever the inputs are
        repeat (2) @(negedge clk);
        bus.opcode = 6'b000010;
        #1 check_eq("reset_outputs", {13'd0, observe()}, 32'd0);
        @(posedge clk);
        #1 check_eq("reset_outputs_edge", {13'd0, observe()}, 32'd0);

        // Directed cases
        run_instr(0, K_ADDU, 1'b1, 1'b0, 0, 1'b0);
        run_instr(1, K_ADD,  1'b1, 1'b0, 0, 1'b0);
        run_instr(2, K_LW,   1'b0, 1'b0, 3, 1'b0);
        run_instr(3, K_BEQ,  1'b0, 1'b1, 0, 1'b0);
        run_instr(4, K_BEQ,  1'b0, 1'b0, 0, 1'b0);
        run_instr(5, K_JAL,  1'b0, 1'b0, 0, 1'b0);
        run_instr(6, K_SW,   1'b0, 1'b0, 3, 1'b1);
        run_instr(7, K_SW,   1'b0, 1'b0, 2, 1'b0);
        run_instr(8, K_SUB,  1'b1, 1'b0, 0, 1'b0);
        run_instr(9, K_ADDI, 1'b1, 1'b0, 0, 1'b0);
        run_instr(10, K_UNKR, 1'b0, 1'b0, 0, 1'b0);
        run_instr(11, K_UNKOP, 1'b0, 1'b0, 0, 1'b0);

        // Random instruction stream
        for (int n = 12; n < 400; n++) begin
            run_instr(n, int'($urandom_range(NKIND - 1)), 1'($urandom), 1'($urandom),
                      int'($urandom_range(4)), ($urandom_range(19) == 0));
        end

        // Every sequence ends by returning to FETCH
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("final_fetch_state", {29'd0, bus.state}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control FSM that sequences the program counter, instruction register, register file, ALU and data memory of the MIPS core. Drives the PC's write enable and next-address select, and raises the one-cycle overflow trap that makes the PC load the exception vector 0x0000_3600. Consumes decoded opcode/funct, the ALU zero/overflow flags and the data-memory ready handshake.

Parameters:
TRAP_ON_UNKNOWN, 0, 1 = an unrecognised opcode/funct goes to TRAP; 0 = treated as NOP and returns to FETCH.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU result == 0
alu_ovf  in  1  ALU signed overflow
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC load enable
pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr)
ir_write  out  1  IR load enable
reg_write  out  1  register file write enable
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
mem_to_reg  out  2  0 = ALU, 1 = memory, 2 = PC (link)
alu_src  out  1  0 = rt, 1 = extended immediate
alu_op  out  2  0 = add, 1 = sub, 2 = or, 3 = lui
ext_op  out  1  1 = sign-extend, 0 = zero-extend
mem_read  out  1  data read request
mem_write  out  1  data write request
ovf_trap  out  1  drives the PC overflow input
state  out  3  current state, for debug

Behaviour:
- Supported: R-type (opcode 000000) addu 100001, subu 100011, add 100000, sub 100010, jr 001000; addi 001000; ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010; jal 000011.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Registered state; all outputs decoded combinationally from state plus opcode/funct/zero.
- rst high (async): state <= FETCH immediately. While rst is high, every enable (pc_write, ir_write, reg_write, mem_read, mem_write, ovf_trap) is forced 0 and selects are 0. The first FETCH starts on the first rising edge after deassertion.
- FETCH: ir_write=1, pc_write=1, pc_src=0 -> DECODE.
- DECODE: j: pc_write=1, pc_src=2 -> FETCH. jal: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2 -> FETCH. jr: pc_write=1, pc_src=3 -> FETCH. Unknown: FETCH, or TRAP if TRAP_ON_UNKNOWN=1. All other instructions -> EXEC.
- EXEC:
  - R-type: alu_src=0; alu_op 0 (add/addu) or 1 (sub/subu).
  - addi: alu_op 0, alu_src=1, ext_op=1.
  - ori: alu_op 2, ext_op=0, alu_src=1.
  - lui: alu_op 3, alu_src=1.
  - lw/sw: alu_op 0, alu_src=1, ext_op=1 -> MEM.
  - beq: alu_op 1, alu_src=0, ext_op=1, pc_src=1, pc_write=zero -> FETCH.
  - add/sub/addi with alu_ovf=1 -> TRAP. Otherwise ALU instructions -> WB.
  - alu_ovf is ignored for addu, subu, ori and lui.
- MEM: mem_read (lw) or mem_write (sw) held high until mem_ready=1. Stalls indefinitely with no timeout. On mem_ready: lw -> WB, sw -> FETCH. mem_ready in any other state is ignored.
- WB: reg_write=1. reg_dst=1 for R-type, 0 otherwise. mem_to_reg=1 for lw, 0 otherwise -> FETCH.
- TRAP: ovf_trap=1 for exactly one cycle, reg_write=0, pc_write=0 -> FETCH. The PC loads 0x3600 on this edge; the faulting destination register is never written.
- CPI: j/jal/jr 2, beq 3, ALU 4, sw 4+wait, lw 5+wait, trap 4.
- rst during MEM: the request drops combinationally and the access is abandoned; no write is committed by the controller.

Test Plan:
- Reset, then release -> state=0, ir_write=pc_write=1, pc_src=0; next cycle state=1; all enables 0 while rst=1.
- addu (000000/100001), alu_ovf=1 -> FETCH,DECODE,EXEC,WB; reg_write=1 with reg_dst=1 in WB only; ovf_trap stays 0.
- add, alu_ovf=1 in EXEC -> state 5 next cycle, ovf_trap=1 for one cycle, reg_write never 1, then FETCH.
- lw with mem_ready held low 3 cycles -> mem_read=1 for 4 cycles, then WB with mem_to_reg=1, reg_dst=0; total 8 cycles.
- beq with zero=1 -> pc_write=1, pc_src=1 in EXEC; with zero=0 -> pc_write=0; both return to FETCH.
- jal -> DECODE asserts pc_write, pc_src=2, reg_write, reg_dst=2, mem_to_reg=2. Repeat with rst pulsed mid-MEM of sw -> mem_write drops immediately, state=0.
